// File: rtl/dispatch_queue.sv
// dispatch_queue: circular instruction buffer with in-order, resource-limited dispatch of up to N entries.
// Packet layout (LSB first): valid, is_br, wr_mem, rd_mem, sq_tail[SQW], lq_tail[LQW], op[OP_W].
`default_nettype none

module dispatch_queue #(
  parameter int N      = 3,
  parameter int DEPTH  = 8,
  parameter int MAX_BR = 1,
  parameter int SQ_SZ  = 8,
  parameter int LQ_SZ  = 8,
  parameter int OP_W   = 8,
  localparam int CW    = $clog2(N + 1),
  localparam int SQW   = $clog2(SQ_SZ),
  localparam int LQW   = $clog2(LQ_SZ),
  localparam int BW    = $clog2(MAX_BR + 1),
  localparam int OCW   = $clog2(DEPTH + 1),
  localparam int PKT_W = 4 + SQW + LQW + OP_W
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               squash_i,
  input  logic [N*PKT_W-1:0] in_insts_i,
  output logic [CW-1:0]      num_accept_o,
  input  logic [CW-1:0]      rob_open_i,
  input  logic [CW-1:0]      rs_open_i,
  input  logic [CW-1:0]      sq_open_i,
  input  logic [CW-1:0]      lq_open_i,
  input  logic [SQW-1:0]     sq_tail_in_i,
  input  logic [LQW-1:0]     lq_tail_in_i,
  input  logic [BW-1:0]      bs_free_i,
  output logic [CW-1:0]      num_dispatch_o,
  output logic [CW-1:0]      num_store_dispatched_o,
  output logic [CW-1:0]      num_load_dispatched_o,
  output logic [N*PKT_W-1:0] out_insts_o,
  output logic [OCW-1:0]     occupancy_o
);

  localparam int PW     = $clog2(DEPTH);
  localparam int F_VAL  = 0;
  localparam int F_BR   = 1;
  localparam int F_ST   = 2;
  localparam int F_LD   = 3;
  localparam int F_SQT  = 4;
  localparam int F_LQT  = 4 + SQW;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OCW-1:0]   count_q, count_d;
  logic             flush;

  assign flush       = reset_i | squash_i;
  assign occupancy_o = count_q;

  // Accept only the leading run of valid lanes; free space comes from registered count only.
  always_comb begin
    int  v;
    int  free;
    int  acc;
    logic live;
    v    = 0;
    live = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (live && in_insts_i[i*PKT_W + F_VAL]) v = v + 1;
      else live = 1'b0;
    end
    free = DEPTH - int'(count_q);
    acc  = (v < free) ? v : free;
    if (flush) acc = 0;
    num_accept_o = CW'(acc);
  end

  always_comb begin
    int   lim;
    int   brcap;
    int   nbr;
    int   nst;
    int   nld;
    int   ndisp;
    logic stop;
    logic ok;
    logic [PW-1:0]    idx;
    logic [PKT_W-1:0] e;
    out_insts_o = '0;
    lim   = int'(count_q);
    if (int'(rob_open_i) < lim) lim = int'(rob_open_i);
    if (int'(rs_open_i) < lim)  lim = int'(rs_open_i);
    brcap = (int'(bs_free_i) < MAX_BR) ? int'(bs_free_i) : MAX_BR;
    nbr   = 0;
    nst   = 0;
    nld   = 0;
    ndisp = 0;
    stop  = 1'b0;
    ok    = 1'b0;
    idx   = '0;
    e     = '0;
    for (int i = 0; i < N; i++) begin
      idx = head_q + PW'(i);
      e   = mem_q[idx];
      if (!stop && (i < lim)) begin
        ok = !(e[F_BR] && (nbr >= brcap)) &&
             !(e[F_ST] && (nst >= int'(sq_open_i))) &&
             !(e[F_LD] && (nld >= int'(lq_open_i)));
        if (ok) begin
          // Stamp with the queue tails as they will stand once older group members are allocated.
          if (e[F_ST] || e[F_LD])
            e[F_SQT +: SQW] = SQW'((int'(sq_tail_in_i) + nst) % SQ_SZ);
          if (e[F_LD])
            e[F_LQT +: LQW] = LQW'((int'(lq_tail_in_i) + nld) % LQ_SZ);
          out_insts_o[i*PKT_W +: PKT_W] = e;
          if (e[F_BR]) nbr = nbr + 1;
          if (e[F_ST]) nst = nst + 1;
          if (e[F_LD]) nld = nld + 1;
          ndisp = ndisp + 1;
        end else begin
          stop = 1'b1;
        end
      end
    end
    if (flush) begin
      out_insts_o = '0;
      ndisp       = 0;
      nst         = 0;
      nld         = 0;
    end
    num_dispatch_o         = CW'(ndisp);
    num_store_dispatched_o = CW'(nst);
    num_load_dispatched_o  = CW'(nld);
  end

  always_comb begin
    head_d  = head_q + PW'(num_dispatch_o);
    tail_d  = tail_q + PW'(num_accept_o);
    count_d = count_q + OCW'(num_accept_o) - OCW'(num_dispatch_o);
    if (squash_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries inside [head, head+count) are ever observed.
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < num_accept_o)
        mem_q[tail_q + PW'(i)] <= in_insts_i[i*PKT_W +: PKT_W];
    end
  end

endmodule

`default_nettype wire
